// File: rtl/rtt_prdcr_arb.sv
// Round-robin arbiter between producer request channels and a grouped
// SWE request slot. A grant is held until the winner drops its request,
// or until a hold limit expires while another slot is waiting. When the
// winner is still busy after release, the arbiter waits in DRAIN.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; arbitrate among requesting slots starting at rr_ptr
// GRANT | one slot (producer channel or locked SWE port) holds the grant
// DRAIN | grant released, waiting for the last winner's busy to clear
module rtt_prdcr_arb #(
    parameter int NUM_PRDCR   = 2,
    parameter int NUM_SWE     = 17,
    parameter int PRNUM_WDT   = 4,
    parameter int PR_BASE_NUM = 0,
    parameter int HOLD_MAX    = 16
) (
    input  logic                 rtt_clk,
    input  logic                 rst_a,
    input  logic [NUM_PRDCR-1:0] prdcr_req,
    input  logic [NUM_PRDCR-1:0] prdcr_busy_in,
    input  logic [NUM_SWE-1:0]   swe_req,
    input  logic                 swe_busy,
    output logic [NUM_PRDCR-1:0] prdcr_gnt,
    output logic [NUM_SWE-1:0]   swe_gnt,
    output logic                 gnt_valid,
    output logic [PRNUM_WDT-1:0] gnt_pr_num,
    output logic                 ored_prdcr_sel_p,
    output logic                 prdcr_busy
);

    localparam int NSLOT = NUM_PRDCR + 1;
    localparam int PW    = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int PW1   = PW + 1;
    localparam int SW    = (NUM_SWE > 1) ? $clog2(NUM_SWE) : 1;
    localparam int HW    = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [PW-1:0] SWE_SLOT = PW'(NUM_PRDCR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [PW-1:0]  rr_ptr, rr_ptr_nxt;
    logic [PW-1:0]  win, win_nxt;
    logic [PW-1:0]  arb_win;
    logic [SW-1:0]  swe_idx, swe_idx_nxt;
    logic [SW-1:0]  swe_low;
    logic [HW-1:0]  hold_cnt, hold_cnt_nxt;
    logic [NSLOT-1:0] req_slot;
    logic [NSLOT-1:0] busy_slot;
    logic [NSLOT-1:0] win_oh;
    logic           arb_any;
    logic           win_req;
    logic           win_busy;
    logic           others_req;
    logic           hold_expire;
    logic           release_gnt;

    // The SWE group occupies the top slot and requests when any port does.
    assign req_slot  = {|swe_req, prdcr_req};
    assign busy_slot = {swe_busy, prdcr_busy_in};
    assign arb_any   = |req_slot;
    assign win_oh    = NSLOT'(1) << win;

    // An SWE winner is judged on its own locked port, not on the group OR.
    assign win_req    = (win == SWE_SLOT) ? swe_req[swe_idx] : req_slot[win];
    assign win_busy   = busy_slot[win];
    assign others_req = |(req_slot & ~win_oh);
    assign hold_expire = (HOLD_MAX != 0) && (hold_cnt == HW'(HOLD_MAX - 1)) && others_req;
    assign release_gnt = !win_req || hold_expire;

    // Rotating priority scan: first requesting slot at or above rr_ptr, with wrap.
    always_comb begin
        logic [PW1-1:0] pos;
        logic           found;
        arb_win = rr_ptr;
        found   = 1'b0;
        pos     = '0;
        for (int i = 0; i < NSLOT; i++) begin
            pos = {1'b0, rr_ptr} + PW1'(i);
            if (pos >= PW1'(NSLOT)) begin
                pos = pos - PW1'(NSLOT);
            end
            if (!found && req_slot[pos[PW-1:0]]) begin
                found   = 1'b1;
                arb_win = pos[PW-1:0];
            end
        end
    end

    // Lowest-index asserted SWE port, captured when the SWE slot wins.
    always_comb begin
        swe_low = '0;
        for (int i = NUM_SWE - 1; i >= 0; i--) begin
            if (swe_req[i]) begin
                swe_low = SW'(i);
            end
        end
    end

    // Next-state, pointer, winner lock and hold counter.
    always_comb begin
        state_nxt    = state;
        rr_ptr_nxt   = rr_ptr;
        win_nxt      = win;
        swe_idx_nxt  = swe_idx;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_nxt    = GRANT;
                    win_nxt      = arb_win;
                    swe_idx_nxt  = swe_low;
                    hold_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (release_gnt) begin
                    rr_ptr_nxt = (win == SWE_SLOT) ? '0 : win + PW'(1);
                    state_nxt  = win_busy ? DRAIN : IDLE;
                end else if (hold_cnt != HW'(HOLD_MAX)) begin
                    hold_cnt_nxt = hold_cnt + HW'(1);
                end
            end
            DRAIN: begin
                if (!win_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge rtt_clk or negedge rst_a) begin
        if (!rst_a) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            win      <= '0;
            swe_idx  <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= rr_ptr_nxt;
            win      <= win_nxt;
            swe_idx  <= swe_idx_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    // Grant outputs are pure decodes of registered state, so they carry no input paths.
    assign gnt_valid  = (state == GRANT);
    assign prdcr_gnt  = (gnt_valid && (win != SWE_SLOT)) ? NUM_PRDCR'(win_oh) : '0;
    assign swe_gnt    = (gnt_valid && (win == SWE_SLOT)) ? (NUM_SWE'(1) << swe_idx) : '0;
    assign gnt_pr_num = gnt_valid ? (PRNUM_WDT'(PR_BASE_NUM) + PRNUM_WDT'(win)) : '0;

    assign ored_prdcr_sel_p = (|prdcr_req) | (|swe_req);
    assign prdcr_busy       = (|prdcr_busy_in) | swe_busy | (state != IDLE);

endmodule

// File: tb/tb_rtt_prdcr_arb.sv
// Bench for rtt_prdcr_arb: vector table, hold-limit rotation through a
// queue of expected grants, drain, mid-grant reset and unlimited hold.
module tb_rtt_prdcr_arb;

    logic        rtt_clk = 1'b0;
    logic        rst_a   = 1'b0;
    logic [1:0]  prdcr_req = '0;
    logic [1:0]  prdcr_busy_in = '0;
    logic [16:0] swe_req = '0;
    logic        swe_busy = 1'b0;
    logic [1:0]  prdcr_gnt;
    logic [16:0] swe_gnt;
    logic        gnt_valid;
    logic [3:0]  gnt_pr_num;
    logic        ored_prdcr_sel_p;
    logic        prdcr_busy;

    logic [1:0]  req_z = '0;
    logic [1:0]  gnt_z;
    logic [16:0] sgnt_z;
    logic        valid_z;
    logic [3:0]  num_z;
    logic        ored_z;
    logic        busy_z;

    rtt_prdcr_arb u_dut (
        .rtt_clk          (rtt_clk),
        .rst_a            (rst_a),
        .prdcr_req        (prdcr_req),
        .prdcr_busy_in    (prdcr_busy_in),
        .swe_req          (swe_req),
        .swe_busy         (swe_busy),
        .prdcr_gnt        (prdcr_gnt),
        .swe_gnt          (swe_gnt),
        .gnt_valid        (gnt_valid),
        .gnt_pr_num       (gnt_pr_num),
        .ored_prdcr_sel_p (ored_prdcr_sel_p),
        .prdcr_busy       (prdcr_busy)
    );

    rtt_prdcr_arb #(.HOLD_MAX(0)) u_dut_nolimit (
        .rtt_clk          (rtt_clk),
        .rst_a            (rst_a),
        .prdcr_req        (req_z),
        .prdcr_busy_in    (2'b00),
        .swe_req          (17'h0),
        .swe_busy         (1'b0),
        .prdcr_gnt        (gnt_z),
        .swe_gnt          (sgnt_z),
        .gnt_valid        (valid_z),
        .gnt_pr_num       (num_z),
        .ored_prdcr_sel_p (ored_z),
        .prdcr_busy       (busy_z)
    );

    always #5 rtt_clk = ~rtt_clk;

    typedef struct packed {
        logic [1:0]  gnt;
        logic [16:0] sgnt;
        logic        valid;
        logic [3:0]  num;
    } exp_t;

    typedef struct packed {
        logic [1:0]  req;
        logic [16:0] swe;
        exp_t        exp;
    } vec_t;

    exp_t sb[$];
    vec_t tv[12];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk_exp(int slot, logic [16:0] sg);
        exp_t e;
        e = '0;
        if (slot == 0 || slot == 1) begin
            e.gnt   = 2'(1 << slot);
            e.valid = 1'b1;
            e.num   = 4'(slot);
        end else if (slot == 2) begin
            e.sgnt  = sg;
            e.valid = 1'b1;
            e.num   = 4'd2;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge rtt_clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_outs(string name);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected entry queued", name);
        end else begin
            e = sb.pop_front();
            if ({prdcr_gnt, swe_gnt, gnt_valid, gnt_pr_num} !== e) begin
                errors++;
                $display("FAIL %s: got gnt=%b swe_gnt=%h valid=%b num=%0d expected gnt=%b swe_gnt=%h valid=%b num=%0d",
                         name, prdcr_gnt, swe_gnt, gnt_valid, gnt_pr_num, e.gnt, e.sgnt, e.valid, e.num);
            end
        end
    endtask

    task automatic do_reset();
        prdcr_req     = '0;
        prdcr_busy_in = '0;
        swe_req       = '0;
        swe_busy      = 1'b0;
        req_z         = '0;
        rst_a         = 1'b0;
        tick();
        rst_a = 1'b1;
    endtask

    initial begin
        int order[4];
        int cnt;

        tv[0]  = '{2'b00, 17'h0,   mk_exp(-1, 17'h0)};
        tv[1]  = '{2'b01, 17'h0,   mk_exp(0, 17'h0)};
        tv[2]  = '{2'b01, 17'h0,   mk_exp(0, 17'h0)};
        tv[3]  = '{2'b00, 17'h0,   mk_exp(-1, 17'h0)};
        tv[4]  = '{2'b11, 17'h0,   mk_exp(1, 17'h0)};
        tv[5]  = '{2'b11, 17'h0,   mk_exp(1, 17'h0)};
        tv[6]  = '{2'b01, 17'h0,   mk_exp(-1, 17'h0)};
        tv[7]  = '{2'b01, 17'h20,  mk_exp(2, 17'h20)};
        tv[8]  = '{2'b01, 17'h220, mk_exp(2, 17'h20)};
        tv[9]  = '{2'b01, 17'h200, mk_exp(-1, 17'h0)};
        tv[10] = '{2'b00, 17'h200, mk_exp(2, 17'h200)};
        tv[11] = '{2'b00, 17'h0,   mk_exp(-1, 17'h0)};

        // Reset state, including requests applied while reset is held.
        rst_a     = 1'b0;
        prdcr_req = 2'b11;
        tick();
        tick();
        sb.push_back(mk_exp(-1, 17'h0));
        check_outs("reset_outputs");
        chk("reset_ored", 32'(ored_prdcr_sel_p), 32'd1);
        prdcr_req = '0;
        swe_req   = 17'h10000;
        #1;
        chk("ored_swe_only", 32'(ored_prdcr_sel_p), 32'd1);
        swe_req = '0;
        #1;
        chk("ored_none", 32'(ored_prdcr_sel_p), 32'd0);
        chk("busy_none", 32'(prdcr_busy), 32'd0);
        swe_busy = 1'b1;
        #1;
        chk("busy_swe", 32'(prdcr_busy), 32'd1);
        swe_busy = 1'b0;
        rst_a = 1'b1;
        tick();

        // Vector table: inputs applied for one edge, outputs checked after it.
        for (int i = 0; i < 12; i++) begin
            prdcr_req = tv[i].req;
            swe_req   = tv[i].swe;
            sb.push_back(tv[i].exp);
            tick();
            check_outs($sformatf("vec%0d", i));
        end

        // Hold-limit rotation: ch0, ch1, SWE port 3, ch0, each for 16 cycles.
        do_reset();
        order[0] = 0;
        order[1] = 1;
        order[2] = 2;
        order[3] = 0;
        prdcr_req = 2'b11;
        swe_req   = 17'h8;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 16; c++) begin
                sb.push_back(mk_exp(order[g], 17'h8));
            end
            if (g < 3) begin
                sb.push_back(mk_exp(-1, 17'h0));
            end
        end
        cnt = 0;
        while (sb.size() > 0 && cnt < 200) begin
            tick();
            check_outs($sformatf("hold_seq_c%0d", cnt));
            cnt++;
        end

        // Drain: ch1 busy for 4 cycles after release.
        do_reset();
        prdcr_req = 2'b10;
        tick();
        chk("drain_pre_gnt", 32'(prdcr_gnt), 32'b10);
        prdcr_req     = 2'b00;
        prdcr_busy_in = 2'b10;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("drain_nognt%0d", k), 32'({prdcr_gnt, gnt_valid}), 32'd0);
            chk($sformatf("drain_busy%0d", k), 32'(prdcr_busy), 32'd1);
        end
        prdcr_busy_in = 2'b00;
        prdcr_req     = 2'b01;
        #1;
        chk("drain_state_busy", 32'(prdcr_busy), 32'd1);
        tick();
        chk("drain_exit_nognt", 32'(gnt_valid), 32'd0);
        chk("drain_exit_busy", 32'(prdcr_busy), 32'd0);
        tick();
        chk("after_drain_gnt", 32'(prdcr_gnt), 32'b01);

        // Reset in the middle of a ch1 grant restarts arbitration at slot 0.
        do_reset();
        prdcr_req = 2'b01;
        tick();
        prdcr_req = 2'b00;
        tick();
        prdcr_req = 2'b11;
        tick();
        chk("pre_reset_gnt_ch1", 32'({prdcr_gnt, gnt_pr_num}), 32'({2'b10, 4'd1}));
        #2;
        rst_a = 1'b0;
        #1;
        chk("midreset_gnt", 32'({prdcr_gnt, swe_gnt, gnt_valid, gnt_pr_num}), 32'd0);
        chk("midreset_ored", 32'(ored_prdcr_sel_p), 32'd1);
        prdcr_busy_in = 2'b01;
        #1;
        chk("midreset_busy_in", 32'(prdcr_busy), 32'd1);
        prdcr_busy_in = 2'b00;
        #1;
        chk("midreset_busy_idle", 32'(prdcr_busy), 32'd0);
        tick();
        rst_a = 1'b1;
        tick();
        chk("postreset_ch0", 32'({prdcr_gnt, gnt_pr_num}), 32'({2'b01, 4'd0}));

        // Unlimited hold: ch0 keeps the grant for 100 cycles with ch1 waiting.
        do_reset();
        req_z = 2'b11;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (gnt_z == 2'b01 && valid_z) begin
                cnt++;
            end
        end
        chk("nolimit_hold_cycles", 32'(cnt), 32'd100);
        req_z = 2'b10;
        tick();
        chk("nolimit_release", 32'(valid_z), 32'd0);
        tick();
        chk("nolimit_next_ch1", 32'({gnt_z, num_z}), 32'({2'b10, 4'd1}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
